// File: rtl/register_file.sv
// Register file with per-register pending-write scoreboard.
// Ports: clk/rst, S/M read ports with hazard, issue reserve, writeback, errFlag.
module register_file #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    PEND_MAX   = 3,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            registerS,
    input  logic [3:0]            registerM,
    input  logic                  useS,
    input  logic                  useM,
    output logic [DATA_WIDTH-1:0] dataS,
    output logic [DATA_WIDTH-1:0] dataM,
    output logic                  hazard,
    input  logic                  issueValid,
    input  logic [3:0]            issueDest,
    output logic                  issueFull,
    input  logic                  writeEnable,
    input  logic [3:0]            writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic                  errFlag
);

    localparam int         NREG    = 12;
    localparam int         SP_IDX  = 9;
    localparam logic [1:0] CNT_MAX = 2'(PEND_MAX);

    logic [DATA_WIDTH-1:0] regs     [NREG];
    logic [1:0]            cnt      [NREG];
    logic [1:0]            cnt_next [NREG];

    logic [NREG-1:0]       rel_vec;
    logic [NREG-1:0]       acc_vec;
    logic [DATA_WIDTH-1:0] rd_s;
    logic [DATA_WIDTH-1:0] rd_m;
    logic                  hz_next;
    logic                  err_hit;

    // Release: a writeback retires one reservation, if any exists.
    always_comb begin
        rel_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            rel_vec[i] = writeEnable && (writeAddr == 4'(i))
                         && (cnt[i] != 2'd0);
        end
    end

    // A saturated slot still accepts when the same cycle frees it.
    always_comb begin
        issueFull = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (issueValid && (issueDest == 4'(i))
                && (cnt[i] == CNT_MAX) && !rel_vec[i]) begin
                issueFull = 1'b1;
            end
        end
    end

    always_comb begin
        acc_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            acc_vec[i] = issueValid && (issueDest == 4'(i)) && !issueFull;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_next[i] = cnt[i] + {1'b0, acc_vec[i]} - {1'b0, rel_vec[i]};
        end
    end

    // Hazard looks at next-cycle counts so it lines up with the read data.
    always_comb begin
        hz_next = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (useS && (registerS == 4'(i)) && (cnt_next[i] != 2'd0)) begin
                hz_next = 1'b1;
            end
            if (useM && (registerM == 4'(i)) && (cnt_next[i] != 2'd0)) begin
                hz_next = 1'b1;
            end
        end
    end

    // Read muxes with write-through bypass; unmapped indices read 0.
    always_comb begin
        rd_s = '0;
        rd_m = '0;
        for (int i = 0; i < NREG; i++) begin
            if (registerS == 4'(i)) begin
                rd_s = (writeEnable && (writeAddr == 4'(i)))
                       ? writeData : regs[i];
            end
            if (registerM == 4'(i)) begin
                rd_m = (writeEnable && (writeAddr == 4'(i)))
                       ? writeData : regs[i];
            end
        end
    end

    always_comb begin
        err_hit = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (writeEnable && (writeAddr == 4'(i)) && (cnt[i] == 2'd0)) begin
                err_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
                cnt[i]  <= 2'd0;
            end
            dataS   <= '0;
            dataM   <= '0;
            hazard  <= 1'b0;
            errFlag <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (writeEnable && (writeAddr == 4'(i))) begin
                    regs[i] <= writeData;
                end
                cnt[i] <= cnt_next[i];
            end
            dataS  <= rd_s;
            dataM  <= rd_m;
            hazard <= hz_next;
            if (err_hit) begin
                errFlag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: vector table, corner sequences, random vs model.
// Drives at negedge, checks issueFull before the edge and outputs after it.
module tb_register_file;

    localparam logic [15:0] SPR = 16'h5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  registerS = '0;
    logic [3:0]  registerM = '0;
    logic        useS = 1'b0;
    logic        useM = 1'b0;
    logic [15:0] dataS;
    logic [15:0] dataM;
    logic        hazard;
    logic        issueValid = 1'b0;
    logic [3:0]  issueDest = '0;
    logic        issueFull;
    logic        writeEnable = 1'b0;
    logic [3:0]  writeAddr = '0;
    logic [15:0] writeData = '0;
    logic        errFlag;

    register_file #(.DATA_WIDTH(16), .PEND_MAX(3), .SP_RESET(SPR)) dut (
        .clk(clk), .rst(rst),
        .registerS(registerS), .registerM(registerM),
        .useS(useS), .useM(useM),
        .dataS(dataS), .dataM(dataM), .hazard(hazard),
        .issueValid(issueValid), .issueDest(issueDest),
        .issueFull(issueFull),
        .writeEnable(writeEnable), .writeAddr(writeAddr),
        .writeData(writeData), .errFlag(errFlag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural values and outstanding-write counts.
    logic [15:0] mreg [16];
    int          mcnt [16];
    logic        merr;
    logic [15:0] e_ds, e_dm;
    logic        e_hz, e_full;
    logic        last_full;

    function automatic bit mapped(input logic [3:0] a);
        return a < 4'd12;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mreg[i] = (i == 9) ? SPR : 16'h0;
            mcnt[i] = 0;
        end
        merr = 1'b0;
        e_ds = '0;
        e_dm = '0;
        e_hz = 1'b0;
    endtask

    task automatic model_full(input logic iv, input logic [3:0] id,
                              input logic we, input logic [3:0] wa);
        e_full = iv && mapped(id) && mcnt[id] == 3 && !(we && wa == id);
    endtask

    task automatic model_step(input logic [3:0] s, m, input logic us, um,
                              input logic iv, input logic [3:0] id,
                              input logic we, input logic [3:0] wa,
                              input logic [15:0] wd);
        int nc [16];
        nc = mcnt;
        if (iv && mapped(id) && !e_full) nc[id]++;
        if (we && mapped(wa) && mcnt[wa] > 0) nc[wa]--;
        e_ds = !mapped(s) ? 16'h0 : (we && wa == s) ? wd : mreg[s];
        e_dm = !mapped(m) ? 16'h0 : (we && wa == m) ? wd : mreg[m];
        e_hz = (us && nc[s] > 0) || (um && nc[m] > 0);
        if (we && mapped(wa) && mcnt[wa] == 0) merr = 1'b1;
        if (we && mapped(wa)) mreg[wa] = wd;
        mcnt = nc;
    endtask

    task automatic cyc(input logic [3:0] s, m, input logic us, um,
                       input logic iv, input logic [3:0] id,
                       input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input bit cmp);
        registerS = s; registerM = m; useS = us; useM = um;
        issueValid = iv; issueDest = id;
        writeEnable = we; writeAddr = wa; writeData = wd;
        #1;
        model_full(iv, id, we, wa);
        last_full = issueFull;
        if (cmp) chk("issueFull", 16'(issueFull), 16'(e_full));
        @(posedge clk);
        model_step(s, m, us, um, iv, id, we, wa, wd);
        #1;
        if (cmp) begin
            chk("dataS", dataS, e_ds);
            chk("dataM", dataM, e_dm);
            chk("hazard", 16'(hazard), 16'(e_hz));
            chk("errFlag", 16'(errFlag), 16'(merr));
        end
        @(negedge clk);
        issueValid = 1'b0;
        writeEnable = 1'b0;
    endtask

    task automatic idle(input bit cmp);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, cmp);
    endtask

    // Assert rst away from any clock edge; outputs must clear at once.
    task automatic pulse_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_rst_dataS"}, dataS, 16'h0);
        chk({tag, "_rst_dataM"}, dataM, 16'h0);
        chk({tag, "_rst_hazard"}, 16'(hazard), 16'h0);
        chk({tag, "_rst_err"}, 16'(errFlag), 16'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  s, m;
        logic        us, um, iv;
        logic [3:0]  id;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [15:0] ds, dm;
        logic        hz, full, err;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [3:0] rnd_idx();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(12, 15));
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 11));
        return 4'($urandom_range(0, 5));
    endfunction

    initial begin
        model_reset();
        tbl[0] = '{9, 0, 0, 0, 0, 0, 0, 0, 16'h0,
                   SPR, 16'h0, 0, 0, 0};
        tbl[1] = '{3, 3, 0, 0, 0, 0, 1, 3, 16'h1234,
                   16'h1234, 16'h1234, 0, 0, 1};
        tbl[2] = '{3, 0, 1, 0, 1, 5, 0, 0, 16'h0,
                   16'h1234, 16'h0, 0, 0, 1};
        tbl[3] = '{5, 0, 1, 0, 0, 0, 0, 0, 16'h0,
                   16'h0, 16'h0, 1, 0, 1};
        tbl[4] = '{5, 0, 1, 0, 0, 0, 1, 5, 16'h00AA,
                   16'h00AA, 16'h0, 0, 0, 1};
        tbl[5] = '{12, 5, 1, 1, 1, 12, 1, 12, 16'hFFFF,
                   16'h0, 16'h00AA, 0, 0, 1};
        tbl[6] = '{12, 3, 1, 0, 0, 0, 0, 0, 16'h0,
                   16'h0, 16'h1234, 0, 0, 1};

        #2;
        chk("init_dataS", dataS, 16'h0);
        chk("init_hazard", 16'(hazard), 16'h0);
        chk("init_err", 16'(errFlag), 16'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].s, tbl[i].m, tbl[i].us, tbl[i].um, tbl[i].iv,
                tbl[i].id, tbl[i].we, tbl[i].wa, tbl[i].wd, 0);
            chk($sformatf("v%0d_full", i), 16'(last_full), 16'(tbl[i].full));
            chk($sformatf("v%0d_dataS", i), dataS, tbl[i].ds);
            chk($sformatf("v%0d_dataM", i), dataM, tbl[i].dm);
            chk($sformatf("v%0d_hazard", i), 16'(hazard), 16'(tbl[i].hz));
            chk($sformatf("v%0d_err", i), 16'(errFlag), 16'(tbl[i].err));
        end

        // Saturation: three reservations fill R2.
        pulse_reset("sat");
        repeat (3) cyc(2, 0, 1, 0, 1, 2, 0, 0, 16'h0, 1);
        chk("sat_hazard", 16'(hazard), 16'h1);
        cyc(2, 0, 1, 0, 1, 2, 0, 0, 16'h0, 1);
        chk("sat_full", 16'(last_full), 16'h1);
        cyc(2, 0, 1, 0, 1, 2, 1, 2, 16'h0101, 1);
        chk("sat_accept_rel", 16'(last_full), 16'h0);
        chk("sat_accept_err", 16'(errFlag), 16'h0);
        cyc(2, 0, 1, 0, 1, 2, 0, 0, 16'h0, 1);
        chk("sat_still3", 16'(last_full), 16'h1);
        cyc(2, 0, 1, 0, 0, 0, 1, 2, 16'h0202, 1);
        cyc(2, 0, 1, 0, 0, 0, 1, 2, 16'h0303, 1);
        chk("sat_one_left", 16'(hazard), 16'h1);
        cyc(2, 0, 1, 0, 0, 0, 1, 2, 16'h0404, 1);
        chk("sat_drained_hz", 16'(hazard), 16'h0);
        chk("sat_drained_data", dataS, 16'h0404);
        chk("sat_drained_err", 16'(errFlag), 16'h0);
        cyc(2, 0, 1, 0, 0, 0, 1, 2, 16'h0505, 1);
        chk("sat_extra_err", 16'(errFlag), 16'h1);

        // Mid-operation reset with R1 and R4 pending.
        pulse_reset("mid0");
        cyc(0, 0, 0, 0, 1, 1, 1, 3, 16'h7777, 1);
        cyc(1, 4, 1, 1, 1, 4, 0, 0, 16'h0, 1);
        chk("mid_hazard", 16'(hazard), 16'h1);
        chk("mid_dataM", dataM, 16'h0);
        pulse_reset("mid");
        cyc(1, 4, 1, 1, 0, 0, 0, 0, 16'h0, 1);
        chk("mid_after_hz", 16'(hazard), 16'h0);
        cyc(1, 0, 1, 0, 0, 0, 1, 1, 16'h4321, 1);
        chk("mid_after_err", 16'(errFlag), 16'h1);
        chk("mid_after_data", dataS, 16'h4321);
        cyc(3, 9, 0, 0, 0, 0, 0, 0, 16'h0, 1);
        chk("mid_r3_cleared", dataS, 16'h0);
        chk("mid_sp", dataM, SPR);

        // Random traffic against the model.
        pulse_reset("rnd");
        for (int n = 0; n < 600; n++) begin
            cyc(rnd_idx(), rnd_idx(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                rnd_idx(), ($urandom_range(0, 2) != 0), rnd_idx(),
                16'($urandom), 1);
            if (n == 300) pulse_reset("rnd_mid");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
